// File: rtl/screen_write_ctrl.sv
// Write-port arbiter for the Hack screen frame buffer: CPU writes always win, a fill engine
// sweeps a constant pattern over every word using the cycles the CPU leaves free.
module screen_write_ctrl #(
  parameter int unsigned ADDR_WIDTH = 13,
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned DEPTH      = 8192
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  cpu_load,
  input  logic [ADDR_WIDTH-1:0] cpu_address,
  input  logic [DATA_WIDTH-1:0] cpu_data,
  input  logic                  fill_start,
  input  logic [DATA_WIDTH-1:0] fill_value,
  input  logic                  fill_abort,
  output logic                  fb_load,
  output logic [ADDR_WIDTH-1:0] fb_address,
  output logic [DATA_WIDTH-1:0] fb_data,
  output logic                  fill_busy,
  output logic                  fill_done,
  output logic [ADDR_WIDTH-1:0] fill_addr
);

  localparam logic [ADDR_WIDTH-1:0] LastAddr = ADDR_WIDTH'(DEPTH - 1);

  typedef enum logic [1:0] {StIdle, StFill, StDone} state_e;

  state_e                state_q, state_d;
  logic [DATA_WIDTH-1:0] pattern_q, pattern_d;
  logic [ADDR_WIDTH-1:0] fill_addr_q, fill_addr_d;
  logic                  fill_busy_q, fill_busy_d;
  logic                  fill_done_q, fill_done_d;
  logic                  fb_load_q, fb_load_d;
  logic [ADDR_WIDTH-1:0] fb_address_q, fb_address_d;
  logic [DATA_WIDTH-1:0] fb_data_q, fb_data_d;

  always_comb begin
    state_d      = state_q;
    pattern_d    = pattern_q;
    fill_addr_d  = fill_addr_q;
    fill_busy_d  = fill_busy_q;
    fill_done_d  = 1'b0;
    fb_load_d    = 1'b0;
    fb_address_d = fb_address_q;
    fb_data_d    = fb_data_q;

    // The CPU cannot stall, so its write is registered in every state.
    if (cpu_load) begin
      fb_load_d    = 1'b1;
      fb_address_d = cpu_address;
      fb_data_d    = cpu_data;
    end

    case (state_q)
      StIdle: begin
        if (fill_start) begin
          pattern_d   = fill_value;
          fill_addr_d = '0;
          fill_busy_d = 1'b1;
          state_d     = StFill;
        end
      end
      StFill: begin
        if (fill_abort) begin
          fill_busy_d = 1'b0;
          state_d     = StIdle;
        end else if (!cpu_load) begin
          fb_load_d    = 1'b1;
          fb_address_d = fill_addr_q;
          fb_data_d    = pattern_q;
          if (fill_addr_q == LastAddr) begin
            fill_addr_d = '0;
            state_d     = StDone;
          end else begin
            fill_addr_d = fill_addr_q + ADDR_WIDTH'(1);
          end
        end
      end
      StDone: begin
        fill_done_d = 1'b1;
        fill_busy_d = 1'b0;
        state_d     = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= StIdle;
      pattern_q    <= '0;
      fill_addr_q  <= '0;
      fill_busy_q  <= 1'b0;
      fill_done_q  <= 1'b0;
      fb_load_q    <= 1'b0;
      fb_address_q <= '0;
      fb_data_q    <= '0;
    end else begin
      state_q      <= state_d;
      pattern_q    <= pattern_d;
      fill_addr_q  <= fill_addr_d;
      fill_busy_q  <= fill_busy_d;
      fill_done_q  <= fill_done_d;
      fb_load_q    <= fb_load_d;
      fb_address_q <= fb_address_d;
      fb_data_q    <= fb_data_d;
    end
  end

  assign fb_load    = fb_load_q;
  assign fb_address = fb_address_q;
  assign fb_data    = fb_data_q;
  assign fill_busy  = fill_busy_q;
  assign fill_done  = fill_done_q;
  assign fill_addr  = fill_addr_q;

endmodule

// File: tb/tb_screen_write_ctrl.sv
// Bench for screen_write_ctrl: every expected frame-buffer write is queued when stimulus is
// driven and popped by a monitor as the DUT emits it.
module tb_screen_write_ctrl;

  localparam int AW    = 13;
  localparam int DW    = 16;
  localparam int DEPTH = 8192;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wr_t;

  logic          clk;
  logic          reset_n;
  logic          cpu_load;
  logic [AW-1:0] cpu_address;
  logic [DW-1:0] cpu_data;
  logic          fill_start;
  logic [DW-1:0] fill_value;
  logic          fill_abort;
  logic          fb_load;
  logic [AW-1:0] fb_address;
  logic [DW-1:0] fb_data;
  logic          fill_busy;
  logic          fill_done;
  logic [AW-1:0] fill_addr;

  wr_t exp_q[$];
  int  n_tests = 0;
  int  n_fail  = 0;
  int  cyc     = 0;

  screen_write_ctrl #(
    .ADDR_WIDTH(AW),
    .DATA_WIDTH(DW),
    .DEPTH     (DEPTH)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .cpu_load   (cpu_load),
    .cpu_address(cpu_address),
    .cpu_data   (cpu_data),
    .fill_start (fill_start),
    .fill_value (fill_value),
    .fill_abort (fill_abort),
    .fb_load    (fb_load),
    .fb_address (fb_address),
    .fb_data    (fb_data),
    .fill_busy  (fill_busy),
    .fill_done  (fill_done),
    .fill_addr  (fill_addr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Write monitor: every fb_load must match the head of the expectation queue.
  initial begin
    wr_t e;
    forever begin
      @(negedge clk);
      if (reset_n && fb_load) begin
        n_tests++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL fb_write: got unexpected write addr %h data %h, required none",
                   fb_address, fb_data);
        end else begin
          e = exp_q.pop_front();
          if (fb_address !== e.addr || fb_data !== e.data) begin
            n_fail++;
            $display("FAIL fb_write: got addr %h data %h, required addr %h data %h",
                     fb_address, fb_data, e.addr, e.data);
          end
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1, "watchdog");
  end

  task automatic push_fill(input int lo, input int hi, input logic [DW-1:0] v);
    for (int a = lo; a <= hi; a++) exp_q.push_back('{addr: AW'(a), data: v});
  endtask

  task automatic push_cpu(input logic [AW-1:0] a, input logic [DW-1:0] d);
    exp_q.push_back('{addr: a, data: d});
  endtask

  // Pulses fill_start; returns with t0 = cycle count just after the sampling edge.
  task automatic start_fill(input logic [DW-1:0] v, output int t0);
    @(posedge clk); #1;
    fill_start = 1'b1;
    fill_value = v;
    @(posedge clk); #1;
    fill_start = 1'b0;
    t0 = cyc;
  endtask

  task automatic wait_done(input int t0, output int lat);
    lat = -1;
    for (int i = 0; i < DEPTH + 200; i++) begin
      @(posedge clk); #1;
      if (fill_done) begin
        lat = cyc - t0;
        break;
      end
    end
  endtask

  task automatic check_drained(input string name);
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL %s drained: got %0d writes still pending, required 0", name, exp_q.size());
    end
  endtask

  task automatic test_reset;
    #1;
    n_tests++;
    if ({fb_load, fb_address, fb_data, fill_busy, fill_done, fill_addr} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got load %b addr %h data %h busy %b done %b faddr %h, required all 0",
               fb_load, fb_address, fb_data, fill_busy, fill_done, fill_addr);
    end
    @(negedge clk); #1;
    reset_n = 1'b1;
  endtask

  task automatic test_reset_mid_sweep;
    int t0, dones, busys;
    push_fill(0, 99, 16'hFFFF);
    start_fill(16'hFFFF, t0);
    repeat (100) @(posedge clk);
    #1;
    n_tests++;
    if (fill_addr !== AW'(100)) begin
      n_fail++;
      $display("FAIL rst_mid fill_addr: got %h, required %h", fill_addr, AW'(100));
    end
    @(negedge clk); #1;
    reset_n = 1'b0;
    #1;
    n_tests++;
    if ({fb_load, fb_address, fb_data, fill_busy, fill_done, fill_addr} !== '0) begin
      n_fail++;
      $display("FAIL rst_mid outputs: got load %b addr %h data %h busy %b faddr %h, required all 0",
               fb_load, fb_address, fb_data, fill_busy, fill_addr);
    end
    @(negedge clk); #1;
    reset_n = 1'b1;
    dones = 0;
    busys = 0;
    repeat (20) begin
      @(posedge clk); #1;
      if (fill_done) dones++;
      if (fill_busy) busys++;
    end
    n_tests++;
    if (dones != 0 || busys != 0) begin
      n_fail++;
      $display("FAIL rst_mid after: got done %0d busy %0d cycles, required 0 and 0", dones, busys);
    end
    check_drained("rst_mid");
  endtask

  task automatic test_idle_cpu;
    @(posedge clk); #1;
    cpu_load    = 1'b1;
    cpu_address = 13'h0010;
    cpu_data    = 16'hA5A5;
    push_cpu(13'h0010, 16'hA5A5);
    @(posedge clk); #1;
    cpu_load = 1'b0;
    n_tests++;
    if (fb_load !== 1'b1) begin
      n_fail++;
      $display("FAIL idle_cpu load: got %b, required 1", fb_load);
    end
    @(posedge clk); #1;
    n_tests++;
    if (fb_load !== 1'b0 || fb_address !== 13'h0010 || fb_data !== 16'hA5A5) begin
      n_fail++;
      $display("FAIL idle_cpu hold: got load %b addr %h data %h, required 0 0010 a5a5",
               fb_load, fb_address, fb_data);
    end
    check_drained("idle_cpu");
  endtask

  task automatic test_clean_fill;
    int t0;
    push_fill(0, DEPTH - 1, 16'h0000);
    start_fill(16'h0000, t0);
    n_tests++;
    if (fill_busy !== 1'b1 || fill_addr !== '0) begin
      n_fail++;
      $display("FAIL clean busy_rise: got busy %b faddr %h, required 1 0000", fill_busy, fill_addr);
    end
    for (int i = 0; i < DEPTH + 10 && cyc - t0 < DEPTH; i++) begin
      @(posedge clk); #1;
    end
    n_tests++;
    if (fill_done !== 1'b0 || fill_busy !== 1'b1) begin
      n_fail++;
      $display("FAIL clean pre_done: got done %b busy %b, required 0 1", fill_done, fill_busy);
    end
    // Start request in the DONE cycle must be ignored.
    fill_start = 1'b1;
    fill_value = 16'hFFFF;
    @(posedge clk); #1;
    fill_start = 1'b0;
    n_tests++;
    if (fill_done !== 1'b1 || fill_busy !== 1'b0 || cyc - t0 != DEPTH + 1) begin
      n_fail++;
      $display("FAIL clean done: got done %b busy %b at +%0d, required 1 0 at +%0d",
               fill_done, fill_busy, cyc - t0, DEPTH + 1);
    end
    @(posedge clk); #1;
    n_tests++;
    if (fill_done !== 1'b0 || fill_busy !== 1'b0 || fill_addr !== '0) begin
      n_fail++;
      $display("FAIL clean post_done: got done %b busy %b faddr %h, required 0 0 0000",
               fill_done, fill_busy, fill_addr);
    end
    repeat (5) @(posedge clk);
    #1;
    check_drained("clean");
  endtask

  task automatic test_cpu_contention;
    int t0, lat;
    push_fill(0, 49, 16'hC3C3);
    start_fill(16'hC3C3, t0);
    repeat (50) @(posedge clk);
    #1;
    n_tests++;
    if (fill_addr !== AW'(50)) begin
      n_fail++;
      $display("FAIL contention fill_addr: got %h, required %h", fill_addr, AW'(50));
    end
    for (int k = 0; k < 3; k++) push_cpu(AW'(13'h1F00 + k), DW'(16'hD000 + k));
    push_fill(50, DEPTH - 1, 16'hC3C3);
    for (int k = 0; k < 3; k++) begin
      cpu_load    = 1'b1;
      cpu_address = AW'(13'h1F00 + k);
      cpu_data    = DW'(16'hD000 + k);
      @(posedge clk); #1;
    end
    cpu_load = 1'b0;
    n_tests++;
    if (fill_addr !== AW'(50)) begin
      n_fail++;
      $display("FAIL contention hold: got %h, required %h", fill_addr, AW'(50));
    end
    wait_done(t0, lat);
    n_tests++;
    if (lat != DEPTH + 4) begin
      n_fail++;
      $display("FAIL contention latency: got %0d, required %0d", lat, DEPTH + 4);
    end
    repeat (3) @(posedge clk);
    #1;
    check_drained("contention");
  endtask

  task automatic test_abort_and_ignore;
    int t0, lat, dones;
    push_fill(0, 3999, 16'h1234);
    start_fill(16'h1234, t0);
    repeat (4000) @(posedge clk);
    #1;
    fill_abort = 1'b1;
    @(posedge clk); #1;
    fill_abort = 1'b0;
    n_tests++;
    if (fill_busy !== 1'b0 || fill_addr !== AW'(4000)) begin
      n_fail++;
      $display("FAIL abort state: got busy %b faddr %h, required 0 %h",
               fill_busy, fill_addr, AW'(4000));
    end
    dones = 0;
    repeat (10) begin
      @(posedge clk); #1;
      if (fill_done) dones++;
    end
    n_tests++;
    if (dones != 0) begin
      n_fail++;
      $display("FAIL abort done: got %0d pulses, required 0", dones);
    end
    check_drained("abort");

    push_fill(0, DEPTH - 1, 16'h5A5A);
    start_fill(16'h5A5A, t0);
    repeat (10) @(posedge clk);
    #1;
    fill_start = 1'b1;
    fill_value = 16'hFFFF;
    @(posedge clk); #1;
    fill_start = 1'b0;
    n_tests++;
    if (fill_addr !== AW'(11) || fill_busy !== 1'b1) begin
      n_fail++;
      $display("FAIL restart_ignored: got faddr %h busy %b, required %h 1",
               fill_addr, fill_busy, AW'(11));
    end
    wait_done(t0, lat);
    n_tests++;
    if (lat != DEPTH + 1) begin
      n_fail++;
      $display("FAIL second_sweep latency: got %0d, required %0d", lat, DEPTH + 1);
    end
    repeat (3) @(posedge clk);
    #1;
    check_drained("second_sweep");
  endtask

  task automatic test_collision_on_start;
    int t0, lat;
    push_cpu(13'h0005, 16'hBEEF);
    push_fill(0, DEPTH - 1, 16'h1111);
    @(posedge clk); #1;
    fill_start  = 1'b1;
    fill_value  = 16'h1111;
    cpu_load    = 1'b1;
    cpu_address = 13'h0005;
    cpu_data    = 16'hBEEF;
    @(posedge clk); #1;
    fill_start = 1'b0;
    cpu_load   = 1'b0;
    t0 = cyc;
    n_tests++;
    if (fb_load !== 1'b1 || fb_address !== 13'h0005 || fb_data !== 16'hBEEF) begin
      n_fail++;
      $display("FAIL collision first: got load %b addr %h data %h, required 1 0005 beef",
               fb_load, fb_address, fb_data);
    end
    wait_done(t0, lat);
    n_tests++;
    if (lat != DEPTH + 1) begin
      n_fail++;
      $display("FAIL collision latency: got %0d, required %0d", lat, DEPTH + 1);
    end
    repeat (3) @(posedge clk);
    #1;
    check_drained("collision");
  endtask

  initial begin
    reset_n     = 1'b0;
    cpu_load    = 1'b0;
    cpu_address = '0;
    cpu_data    = '0;
    fill_start  = 1'b0;
    fill_value  = '0;
    fill_abort  = 1'b0;
    test_reset();
    test_reset_mid_sweep();
    test_idle_cpu();
    test_clean_fill();
    test_cpu_contention();
    test_abort_and_ignore();
    test_collision_on_start();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/screen_write_ctrl.md
Name: screen_write_ctrl

Overview:
Write-port controller for the Hack screen frame buffer RAM (8192 x 16-bit words, 512x256 pixels).
It shares the single RAM write port between the Hack CPU's memory-mapped screen writes and a hardware fill/clear engine that sweeps every word with a constant pattern.
CPU writes always win, because the CPU cannot stall. The fill engine uses only the cycles the CPU leaves free.
All outputs are registered and drive the frame buffer's write_address/data_in/load inputs directly.

Parameters:
ADDR_WIDTH, 13, width of a screen word address
DATA_WIDTH, 16, width of a screen word (16 pixels)
DEPTH, 8192, number of words swept by a fill; the sweep covers addresses 0..DEPTH-1

Ports:
clk  input  1  system clock; all state changes on its rising edge
reset_n  input  1  asynchronous, active-low reset
cpu_load  input  1  CPU screen write strobe, one word per cycle while high
cpu_address  input  ADDR_WIDTH  CPU screen word address
cpu_data  input  DATA_WIDTH  CPU screen word data
fill_start  input  1  single-cycle pulse that starts a fill sweep
fill_value  input  DATA_WIDTH  pattern to fill with; sampled only in the cycle fill_start is accepted
fill_abort  input  1  stops an active sweep
fb_load  output  1  write enable to the frame buffer
fb_address  output  ADDR_WIDTH  write address to the frame buffer
fb_data  output  DATA_WIDTH  write data to the frame buffer
fill_busy  output  1  high while a sweep is active
fill_done  output  1  one-cycle pulse when a sweep completes normally
fill_addr  output  ADDR_WIDTH  next address the sweep will write (progress indicator)

Behaviour:
- Reset (reset_n low, asynchronous): state=IDLE; fb_load=0, fb_address=0, fb_data=0, fill_busy=0, fill_done=0, fill_addr=0; latched pattern=0. Reset during a sweep abandons it with no done pulse.
- States are IDLE, FILL and DONE.
- IDLE:
  - On fill_start=1, latch fill_value, set fill_addr=0 and go to FILL.
  - fill_busy rises on the edge that samples fill_start.
- FILL, per cycle:
  - If cpu_load=1, the CPU is granted and fill_addr holds.
  - Otherwise the fill is granted: write (fill_addr, pattern) and increment fill_addr.
  - The grant that writes DEPTH-1 moves the state to DONE; fill_addr wraps to 0.
- DONE (one cycle):
  - fill_done=1 and fill_busy=0, then return to IDLE.
  - A fill_start seen during DONE is ignored.
- fill_abort=1 in FILL:
  - Go to IDLE and clear fill_busy; no done pulse.
  - Any fill write granted in that same cycle is suppressed.
  - fill_addr keeps its last value.
  - fill_abort in IDLE or DONE has no effect.
- fill_start while fill_busy=1 is ignored; there is no restart and the pattern is not re-latched.
- Output register, 1-cycle latency: the fb_* values driven in cycle n+1 reflect the grant decided in cycle n.
  - CPU grant: fb_load=1, fb_address=cpu_address, fb_data=cpu_data.
  - Fill grant: fb_load=1, fb_address=fill_addr, fb_data=pattern.
  - No grant: fb_load=0; fb_address and fb_data hold their previous values.
- A CPU write is never dropped or delayed beyond the fixed 1-cycle latency, in any state, including the cycle fill_start is accepted.
- Simultaneous fill_start and cpu_load: the CPU write is output next cycle; the sweep's first possible grant is the following cycle.
- Sweep length: with no CPU traffic, exactly DEPTH fill writes, fill_done exactly DEPTH+1 cycles after the fill_start sample edge. Each CPU write during FILL adds exactly one cycle.
- Ordering: a CPU write to an address not yet swept will later be overwritten by the fill. This is intended clear-screen semantics. Software waits for fill_done before drawing.
- Arithmetic: fill_addr is ADDR_WIDTH bits, unsigned. The terminal compare is against DEPTH-1, so DEPTH < 2^ADDR_WIDTH also works.

Test Plan:
1. Reset mid-sweep: start fill 16'hFFFF, assert reset_n=0 at fill_addr=100 -> all outputs 0 immediately; after release, no writes and no fill_done.
2. Idle CPU traffic: cpu_load with addr 13'h0010, data 16'hA5A5 at cycle n -> fb_load=1, fb_address=13'h0010, fb_data=16'hA5A5 at n+1; fb_load=0 at n+2 once cpu_load drops.
3. Clean fill: fill_start with fill_value=16'h0000, no CPU traffic -> 8192 consecutive writes at addresses 0..8191, all 16'h0000; fill_done pulses at cycle +8193; fill_busy falls the same cycle.
4. CPU contention: during the sweep at fill_addr=50, hold cpu_load for 3 cycles (addresses 13'h1F00..13'h1F02) -> those 3 writes appear in order; fill resumes at address 50 with no gap or duplicate; fill_done is delayed by exactly 3 cycles.
5. Abort and ignore: fill_abort at fill_addr=4000 -> fill_busy=0, no done pulse, no fill write of address 4000. A second fill_start while busy in a new sweep -> pattern unchanged and fill_addr not reset.
6. Collision on start: fill_start and cpu_load (addr 13'h0005) in the same cycle -> the CPU write is output first; address 0 fill write follows one cycle later.
